// File: rtl/color_bar_sched_pkg.sv
// Shared definitions for the colour-bar scheduler and pixel generator:
// state encoding, default geometry and palette mode codes.
package color_bar_defs;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_PAUSE = 2'd1;
   localparam logic [1:0] ST_STEP  = 2'd2;

   typedef enum logic [1:0] {
      RUN   = ST_RUN,
      PAUSE = ST_PAUSE,
      STEP  = ST_STEP
   } schedState_e;

   localparam int DEF_H_ACTIVE  = 640;
   localparam int DEF_STEP_PX   = 4;
   localparam int DEF_NUM_MODES = 4;

   // Palette codes, also decoded by the generator.
   localparam logic [1:0] MODE_BARS    = 2'd0;
   localparam logic [1:0] MODE_INVERT  = 2'd1;
   localparam logic [1:0] MODE_GRAY    = 2'd2;
   localparam logic [1:0] MODE_CHECKER = 2'd3;

   function automatic logic [1:0] nextMode(input logic [1:0] cur, input int numModes);
      return (int'(cur) >= numModes - 1) ? 2'd0 : cur + 2'd1;
   endfunction

endpackage

// File: rtl/scroll_offset_acc.sv
// Horizontal scroll offset register; wraps modulo H_ACTIVE in either direction.
module scroll_offset_acc #(
   parameter int H_ACTIVE = 640,
   parameter int STEP_PX  = 4
) (
   input  logic       clk_div,
   input  logic       clrn,
   input  logic       adv,
   input  logic       dir,
   output logic [9:0] h_offset
);

   localparam logic [10:0] H_W    = 11'(H_ACTIVE);
   localparam logic [10:0] STEP_W = 11'(STEP_PX);

   logic [9:0]  offset_q, offset_d;
   logic [10:0] cur, incSum, nxt;

   // 11-bit intermediate keeps off+STEP_PX and off+H_ACTIVE exact before the wrap.
   always_comb begin
      cur    = {1'b0, offset_q};
      incSum = cur + STEP_W;
      if (!dir) begin
         nxt = (incSum >= H_W) ? incSum - H_W : incSum;
      end else begin
         nxt = (cur < STEP_W) ? cur + H_W - STEP_W : cur - STEP_W;
      end
      offset_d = adv ? 10'(nxt) : offset_q;
   end

   always_ff @(posedge clk_div or negedge clrn) begin
      if (!clrn) begin
         offset_q <= 10'd0;
      end else begin
         offset_q <= offset_d;
      end
   end

   assign h_offset = offset_q;

endmodule

// File: rtl/color_bar_sched.sv
// Frame-synchronous scroll/mode controller for the colour-bar generator.
// Every offset and mode change lands on a frame_start edge so no frame tears.
module color_bar_sched
   import color_bar_defs::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int STEP_PX   = DEF_STEP_PX,
   parameter int NUM_MODES = DEF_NUM_MODES
) (
   input  logic       clk_div,
   input  logic       clrn,
   input  logic       frame_start,
   input  logic       mode_req,
   input  logic       pause_tgl,
   input  logic       step_req,
   input  logic [1:0] speed,
   input  logic       dir,
   output logic [9:0] h_offset,
   output logic [1:0] mode,
   output logic       paused,
   output logic       step_ack
);

   schedState_e state_q, state_d;
   logic [2:0]  fdiv_q, fdiv_d;
   logic [1:0]  mode_q, mode_d;
   logic        modePend_q, modePend_d;
   logic        paused_q, paused_d;
   logic        stepAck_q, stepAck_d;
   logic [3:0]  divLimit;
   logic        divDone;
   logic        adv;

   // The frame event is judged in the current state; a coincident pause_tgl
   // only affects which state the next frame sees.
   always_comb begin
      divLimit = (4'd1 << speed) - 4'd1;
      divDone  = ({1'b0, fdiv_q} >= divLimit);
      adv      = frame_start && (((state_q == RUN) && divDone) || (state_q == STEP));

      fdiv_d = fdiv_q;
      if (frame_start && (state_q == RUN)) begin
         fdiv_d = divDone ? 3'd0 : fdiv_q + 3'd1;
      end

      mode_d     = mode_q;
      modePend_d = modePend_q;
      if (frame_start && (modePend_q || mode_req)) begin
         mode_d     = nextMode(mode_q, NUM_MODES);
         modePend_d = 1'b0;
      end else if (mode_req) begin
         modePend_d = 1'b1;
      end

      state_d = state_q;
      case (state_q)
         RUN:     if (pause_tgl) state_d = PAUSE;
         PAUSE: begin
            if (pause_tgl)     state_d = RUN;
            else if (step_req) state_d = STEP;
         end
         STEP: begin
            if (pause_tgl)        state_d = RUN;
            else if (frame_start) state_d = PAUSE;
         end
         default: state_d = RUN;
      endcase

      stepAck_d = frame_start && (state_q == STEP);
      paused_d  = (state_d != RUN);
   end

   always_ff @(posedge clk_div or negedge clrn) begin
      if (!clrn) begin
         state_q    <= RUN;
         fdiv_q     <= 3'd0;
         mode_q     <= MODE_BARS;
         modePend_q <= 1'b0;
         paused_q   <= 1'b0;
         stepAck_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fdiv_q     <= fdiv_d;
         mode_q     <= mode_d;
         modePend_q <= modePend_d;
         paused_q   <= paused_d;
         stepAck_q  <= stepAck_d;
      end
   end

   scroll_offset_acc #(
      .H_ACTIVE (H_ACTIVE),
      .STEP_PX  (STEP_PX)
   ) uOffset (
      .clk_div  (clk_div),
      .clrn     (clrn),
      .adv      (adv),
      .dir      (dir),
      .h_offset (h_offset)
   );

   assign mode     = mode_q;
   assign paused   = paused_q;
   assign step_ack = stepAck_q;

endmodule

// File: tb/tb_color_bar_sched.sv
// Scoreboard bench for color_bar_sched: a behavioural model predicts each
// cycle's outputs, queues them, and they are compared one cycle later.
module tb_color_bar_sched;

   localparam int H_ACT = 640;
   localparam int STEP  = 4;
   localparam int NMODE = 4;

   typedef struct {
      int off;
      int mode;
      int paused;
      int ack;
   } expT;

   logic       clk_div = 1'b0;
   logic       clrn = 1'b0;
   logic       frame_start = 1'b0;
   logic       mode_req = 1'b0;
   logic       pause_tgl = 1'b0;
   logic       step_req = 1'b0;
   logic [1:0] speed = 2'd0;
   logic       dir = 1'b0;
   logic [9:0] h_offset;
   logic [1:0] mode;
   logic       paused;
   logic       step_ack;

   expT sb[$];
   int  errCount = 0;
   int  checkCount = 0;

   // 0 = RUN, 1 = PAUSE, 2 = STEP
   int  mState = 0;
   int  mFdiv = 0;
   int  mOff = 0;
   int  mMode = 0;
   bit  mPend = 1'b0;

   color_bar_sched dut (
      .clk_div     (clk_div),
      .clrn        (clrn),
      .frame_start (frame_start),
      .mode_req    (mode_req),
      .pause_tgl   (pause_tgl),
      .step_req    (step_req),
      .speed       (speed),
      .dir         (dir),
      .h_offset    (h_offset),
      .mode        (mode),
      .paused      (paused),
      .step_ack    (step_ack)
   );

   always #5 clk_div = ~clk_div;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
      end
   endtask

   task automatic compareNext(input string tag);
      expT e;
      if (sb.size() == 0) begin
         errCount++;
         $display("[TB] FAIL %s: scoreboard empty, got 0 entries, want 1", tag);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, ".h_offset"}, int'(h_offset), e.off);
         checkOutput({tag, ".mode"},     int'(mode),     e.mode);
         checkOutput({tag, ".paused"},   int'(paused),   e.paused);
         checkOutput({tag, ".step_ack"}, int'(step_ack), e.ack);
      end
   endtask

   // Drive one clock of requests, predict the result, and compare after the edge.
   task automatic applyStimulus(input bit fs, input bit mr, input bit pt, input bit sr);
      expT e;
      int  lim;
      bit  doAdv;
      frame_start = fs;
      mode_req    = mr;
      pause_tgl   = pt;
      step_req    = sr;
      e.ack = 0;
      doAdv = 1'b0;
      lim   = (1 << speed) - 1;
      if (fs) begin
         if (mState == 0) begin
            if (mFdiv >= lim) begin
               doAdv = 1'b1;
               mFdiv = 0;
            end else begin
               mFdiv++;
            end
         end else if (mState == 2) begin
            doAdv = 1'b1;
            e.ack = 1;
         end
      end
      if (doAdv) mOff = (dir == 1'b0) ? (mOff + STEP) % H_ACT : (mOff + H_ACT - STEP) % H_ACT;
      if (fs && (mPend || mr)) begin
         mMode = (mMode + 1) % NMODE;
         mPend = 1'b0;
      end else if (mr) begin
         mPend = 1'b1;
      end
      case (mState)
         0: if (pt) mState = 1;
         1: if (pt) mState = 0; else if (sr) mState = 2;
         default: if (pt) mState = 0; else if (fs) mState = 1;
      endcase
      e.off    = mOff;
      e.mode   = mMode;
      e.paused = (mState != 0) ? 1 : 0;
      sb.push_back(e);
      @(posedge clk_div);
      #1;
      compareNext(fs ? "frame" : "idle");
      frame_start = 1'b0;
      mode_req    = 1'b0;
      pause_tgl   = 1'b0;
      step_req    = 1'b0;
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic doReset();
      expT e;
      clrn = 1'b0;
      #1;
      mState = 0; mFdiv = 0; mOff = 0; mMode = 0; mPend = 1'b0;
      e.off = 0; e.mode = 0; e.paused = 0; e.ack = 0;
      sb.push_back(e);
      compareNext("reset");
      #1;
      clrn = 1'b1;
   endtask

   initial begin
      doReset();

      // Basic scroll at one step per frame.
      speed = 2'd0;
      dir   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0);
         checkOutput("scroll.const", int'(h_offset), 4 * (i + 1));
         applyStimulus(0, 0, 0, 0);
      end

      for (int i = 0; i < 156; i++) begin
         applyStimulus(1, 0, 0, 0);
         applyStimulus(0, 0, 0, 0);
      end
      checkOutput("reach636", int'(h_offset), 636);

      // Four frames per step, then wrap to zero.
      speed = 2'd2;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 0, 0);
         applyStimulus(0, 0, 0, 0);
      end
      checkOutput("wrapRight", int'(h_offset), 0);

      speed = 2'd0;
      dir   = 1'b1;
      applyStimulus(1, 0, 0, 0);
      checkOutput("wrapLeft", int'(h_offset), 636);
      dir = 1'b0;
      applyStimulus(0, 0, 0, 0);

      // Pause, double step request, one committed step.
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0);
      checkOutput("stepAckHigh", int'(step_ack), 1);
      checkOutput("stepOffset", int'(h_offset), 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("stepNoRepeat", int'(h_offset), 0);
      checkOutput("stillPaused", int'(paused), 1);

      // Mode requests: coincident ones, then a burst within one frame.
      applyStimulus(0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      checkOutput("mode3", int'(mode), 3);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("modeWrap", int'(mode), 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("modeHold", int'(mode), 0);

      // Resume, and pause on the frame that advances.
      applyStimulus(0, 0, 1, 0);
      speed = 2'd2;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0);
         applyStimulus(0, 0, 0, 0);
      end
      applyStimulus(1, 0, 1, 0);
      checkOutput("pauseCoincOff", int'(h_offset), 4);
      checkOutput("pauseCoincPaused", int'(paused), 1);
      applyStimulus(0, 0, 0, 0);

      // Reset with a step pending discards it.
      doReset();
      speed = 2'd0;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(1, 0, 0, 0);
         applyStimulus(0, 0, 0, 0);
      end
      checkOutput("reach200", int'(h_offset), 200);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1);
      doReset();
      speed = 2'd2;
      applyStimulus(1, 0, 0, 0);
      checkOutput("noAckAfterReset", int'(step_ack), 0);
      applyStimulus(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
